fetch_unit: RTL and testbench

Instruction-fetch stage that supplies the 16-bit instruction stream consumed by the opcode decoder in ID. It owns the PC, issues requests to instruction memory over a ready-handshake tolerating variable latency, holds one returned instruction in a skid buffer while ID stalls, and redirects on taken branches and `PCS` targets resolved in ID. On accepting `HLT` (opcode `4'b1111`) into IF/ID it stops fetching permanently until reset.

---
 rtl/fetch_unit.sv | 194 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a ready handshake, buffers
// one instruction while ID stalls, redirects on branches and stops on HLT.
module fetch_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [15:0] branch_target_i,
   output logic        imem_req_o,
   output logic [15:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [15:0] imem_rdata_i,
   output logic        if_id_valid_o,
   output logic [15:0] if_id_instr_o,
   output logic [15:0] if_id_pc_next_o,
   output logic        halted_o
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_BUF   = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_e;

   function automatic logic is_hlt(input logic [15:0] instr);
      return (instr[15:12] == 4'b1111);
   endfunction

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [15:0] ifid_instr_q, ifid_instr_d;
   logic [15:0] ifid_pcn_q, ifid_pcn_d;
   logic        skid_valid_q, skid_valid_d;
   logic [15:0] skid_instr_q, skid_instr_d;
   logic [15:0] skid_pcn_q, skid_pcn_d;
   logic        skid_hlt_q, skid_hlt_d;
   logic [15:0] redirect_q, redirect_d;
   logic        halted_q, halted_d;
   logic [15:0] tgt_s;
   logic [15:0] pc_inc_s;

   assign tgt_s    = {branch_target_i[15:1], 1'b0};
   assign pc_inc_s = pc_q + 16'd2;

   // Next-state decode; branch beats stall beats normal flow.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pcn_d   = ifid_pcn_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pcn_d   = skid_pcn_q;
      skid_hlt_d   = skid_hlt_q;
      redirect_d   = redirect_q;
      halted_d     = halted_q;
      case (state_q)
         S_REQ: begin
            if (branch_taken_i) begin
               ifid_valid_d = 1'b0;
               skid_valid_d = 1'b0;
               if (imem_ready_i) begin
                  pc_d = tgt_s;
               end else begin
                  redirect_d = tgt_s;
                  state_d    = S_DRAIN;
               end
            end else if (stall_i) begin
               if (imem_ready_i) begin
                  skid_valid_d = 1'b1;
                  skid_instr_d = imem_rdata_i;
                  skid_pcn_d   = pc_inc_s;
                  skid_hlt_d   = is_hlt(imem_rdata_i);
                  pc_d         = pc_inc_s;
                  state_d      = S_BUF;
               end else begin
                  state_d = S_REQ;
               end
            end else begin
               if (imem_ready_i) begin
                  ifid_valid_d = 1'b1;
                  ifid_instr_d = imem_rdata_i;
                  ifid_pcn_d   = pc_inc_s;
                  pc_d         = pc_inc_s;
                  if (is_hlt(imem_rdata_i)) begin
                     halted_d = 1'b1;
                     state_d  = S_HALT;
                  end else begin
                     state_d = S_REQ;
                  end
               end else begin
                  ifid_valid_d = 1'b0;
               end
            end
         end
         S_BUF: begin
            if (branch_taken_i) begin
               ifid_valid_d = 1'b0;
               skid_valid_d = 1'b0;
               pc_d         = tgt_s;
               state_d      = S_REQ;
            end else if (stall_i) begin
               state_d = S_BUF;
            end else begin
               ifid_valid_d = 1'b1;
               ifid_instr_d = skid_instr_q;
               ifid_pcn_d   = skid_pcn_q;
               skid_valid_d = 1'b0;
               if (skid_hlt_q) begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_DRAIN: begin
            // The outstanding stale request must complete before the redirect is issued.
            if (branch_taken_i) begin
               ifid_valid_d = 1'b0;
               skid_valid_d = 1'b0;
               if (imem_ready_i) begin
                  pc_d    = tgt_s;
                  state_d = S_REQ;
               end else begin
                  redirect_d = tgt_s;
               end
            end else begin
               if (!stall_i) begin
                  ifid_valid_d = 1'b0;
               end else begin
                  ifid_valid_d = ifid_valid_q;
               end
               if (imem_ready_i) begin
                  pc_d    = redirect_q;
                  state_d = S_REQ;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_HALT: begin
            if (!stall_i) begin
               ifid_valid_d = 1'b0;
            end else begin
               ifid_valid_d = ifid_valid_q;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // State, PC, IF/ID and skid registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_REQ;
         pc_q         <= 16'h0000;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= 16'h0000;
         ifid_pcn_q   <= 16'h0000;
         skid_valid_q <= 1'b0;
         skid_instr_q <= 16'h0000;
         skid_pcn_q   <= 16'h0000;
         skid_hlt_q   <= 1'b0;
         redirect_q   <= 16'h0000;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pcn_q   <= ifid_pcn_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pcn_q   <= skid_pcn_d;
         skid_hlt_q   <= skid_hlt_d;
         redirect_q   <= redirect_d;
         halted_q     <= halted_d;
      end
   end

   assign imem_req_o      = (state_q == S_REQ) || (state_q == S_DRAIN);
   assign imem_addr_o     = pc_q;
   assign if_id_valid_o   = ifid_valid_q;
   assign if_id_instr_o   = ifid_instr_q;
   assign if_id_pc_next_o = ifid_pcn_q;
   assign halted_o        = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vectors drive the memory side and
// ID controls, then check the request lines and the registered IF/ID outputs.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, branch_taken_i, imem_ready_i;
   logic [15:0] branch_target_i, imem_rdata_i;
   logic        imem_req_o, if_id_valid_o, halted_o;
   logic [15:0] imem_addr_o, if_id_instr_o, if_id_pc_next_o;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        st;
      logic        br;
      logic [15:0] tgt;
      logic        rdy;
      logic [15:0] rdata;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [15:0] e_instr;
      logic [15:0] e_pcn;
      logic        e_halt;
   } vec_t;

   vec_t tbl[$];

   fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_i         (stall_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_ready_i    (imem_ready_i),
      .imem_rdata_i    (imem_rdata_i),
      .if_id_valid_o   (if_id_valid_o),
      .if_id_instr_o   (if_id_instr_o),
      .if_id_pc_next_o (if_id_pc_next_o),
      .halted_o        (halted_o)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic st, input logic br, input logic [15:0] tgt,
                               input logic rdy, input logic [15:0] rdata,
                               input logic e_req, input logic [15:0] e_addr,
                               input logic e_valid, input logic [15:0] e_instr,
                               input logic [15:0] e_pcn, input logic e_halt);
      vec_t v;
      v.st = st; v.br = br; v.tgt = tgt; v.rdy = rdy; v.rdata = rdata;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_instr = e_instr; v.e_pcn = e_pcn; v.e_halt = e_halt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_regs(input string tag, input logic v, input logic [15:0] i,
                           input logic [15:0] p, input logic h);
      chk({tag, ".valid"},   {15'd0, if_id_valid_o}, {15'd0, v});
      chk({tag, ".instr"},   if_id_instr_o, i);
      chk({tag, ".pc_next"}, if_id_pc_next_o, p);
      chk({tag, ".halted"},  {15'd0, halted_o}, {15'd0, h});
   endtask

   // Drive one cycle, check request lines before the edge and IF/ID after it.
   task automatic step(input vec_t v, input string tag);
      stall_i         = v.st;
      branch_taken_i  = v.br;
      branch_target_i = v.tgt;
      imem_ready_i    = v.rdy;
      imem_rdata_i    = v.rdata;
      #1;
      chk({tag, ".req"},  {15'd0, imem_req_o}, {15'd0, v.e_req});
      chk({tag, ".addr"}, imem_addr_o, v.e_addr);
      @(posedge clk);
      #1;
      chk_regs(tag, v.e_valid, v.e_instr, v.e_pcn, v.e_halt);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = 16'h0000;
      imem_ready_i = 1'b0; imem_rdata_i = 16'h0000;
      #1;
      chk({tag, ".req"},  {15'd0, imem_req_o}, 16'h0001);
      chk({tag, ".addr"}, imem_addr_o, 16'h0000);
      chk_regs(tag, 1'b0, 16'h0000, 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] a;
      // st br tgt rdy rdata | req addr | valid instr pc_next halted
      tbl.push_back(mk(0,0,16'h0000,1,16'h0000, 1,16'h0000, 1,16'h0000,16'h0002,0));
      tbl.push_back(mk(0,0,16'h0000,1,16'h0002, 1,16'h0002, 1,16'h0002,16'h0004,0));
      tbl.push_back(mk(0,0,16'h0000,1,16'h0004, 1,16'h0004, 1,16'h0004,16'h0006,0));
      tbl.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h0006, 0,16'h0004,16'h0006,0));
      tbl.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h0006, 0,16'h0004,16'h0006,0));
      tbl.push_back(mk(0,0,16'h0000,1,16'h0006, 1,16'h0006, 1,16'h0006,16'h0008,0));
      tbl.push_back(mk(0,1,16'h0041,1,16'h0008, 1,16'h0008, 0,16'h0006,16'h0008,0));
      tbl.push_back(mk(0,1,16'h000F,1,16'h0040, 1,16'h0040, 0,16'h0006,16'h0008,0));
      tbl.push_back(mk(0,0,16'h0000,1,16'h000E, 1,16'h000E, 1,16'h000E,16'h0010,0));
      tbl.push_back(mk(1,0,16'h0000,1,16'h1234, 1,16'h0010, 1,16'h000E,16'h0010,0));
      tbl.push_back(mk(1,0,16'h0000,0,16'h0000, 0,16'h0012, 1,16'h000E,16'h0010,0));
      tbl.push_back(mk(0,0,16'h0000,0,16'h0000, 0,16'h0012, 1,16'h1234,16'h0012,0));
      tbl.push_back(mk(0,0,16'h0000,1,16'h0012, 1,16'h0012, 1,16'h0012,16'h0014,0));
      tbl.push_back(mk(0,1,16'h0020,1,16'h0014, 1,16'h0014, 0,16'h0012,16'h0014,0));
      tbl.push_back(mk(0,1,16'h0080,0,16'h0000, 1,16'h0020, 0,16'h0012,16'h0014,0));
      tbl.push_back(mk(0,0,16'h0000,0,16'h0000, 1,16'h0020, 0,16'h0012,16'h0014,0));
      tbl.push_back(mk(0,1,16'h00A0,0,16'h0000, 1,16'h0020, 0,16'h0012,16'h0014,0));
      tbl.push_back(mk(0,0,16'h0000,1,16'h0020, 1,16'h0020, 0,16'h0012,16'h0014,0));
      tbl.push_back(mk(0,0,16'h0000,1,16'h00A0, 1,16'h00A0, 1,16'h00A0,16'h00A2,0));
      tbl.push_back(mk(0,1,16'h0030,1,16'h00A2, 1,16'h00A2, 0,16'h00A0,16'h00A2,0));
      tbl.push_back(mk(0,0,16'h0000,1,16'hF000, 1,16'h0030, 1,16'hF000,16'h0032,1));
      tbl.push_back(mk(1,0,16'h0000,1,16'h1111, 0,16'h0032, 1,16'hF000,16'h0032,1));
      tbl.push_back(mk(0,1,16'h0100,1,16'h1111, 0,16'h0032, 0,16'hF000,16'h0032,1));
      tbl.push_back(mk(0,0,16'h0000,0,16'h0000, 0,16'h0032, 0,16'hF000,16'h0032,1));

      do_reset("reset0");
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // Leaving HALT only through reset; then HLT parked in the skid and flushed.
      do_reset("reset1");
      step(mk(0,1,16'h0030,1,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000,0), "skid0");
      step(mk(1,0,16'h0000,1,16'hF000, 1,16'h0030, 0,16'h0000,16'h0000,0), "skid1");
      step(mk(1,0,16'h0000,0,16'h0000, 0,16'h0032, 0,16'h0000,16'h0000,0), "skid2");
      step(mk(1,1,16'h0050,0,16'h0000, 0,16'h0032, 0,16'h0000,16'h0000,0), "skid3");
      step(mk(0,0,16'h0000,1,16'h0050, 1,16'h0050, 1,16'h0050,16'h0052,0), "skid4");

      // PC wrap across 0xFFFE -> 0x0000 with zero-wait memory.
      step(mk(0,1,16'hFFFC,1,16'h0052, 1,16'h0052, 0,16'h0050,16'h0052,0), "wrap_br");
      for (int i = 0; i < 4; i++) begin
         a = 16'hFFFC + 16'(2 * i);
         step(mk(0,0,16'h0000,1,a & 16'h0FFF, 1,a, 1,a & 16'h0FFF,a + 16'h0002,0),
              $sformatf("wrap%0d", i));
      end

      // HLT delivered from the skid buffer does assert halted.
      step(mk(1,0,16'h0000,1,16'hF000, 1,16'h0004, 1,16'h0002,16'h0004,0), "bufhlt0");
      step(mk(0,0,16'h0000,0,16'h0000, 0,16'h0006, 1,16'hF000,16'h0006,1), "bufhlt1");
      step(mk(0,0,16'h0000,1,16'h0000, 0,16'h0006, 0,16'hF000,16'h0006,1), "bufhlt2");

      // Reset dropped onto an outstanding request.
      step(mk(0,0,16'h0000,0,16'h0000, 0,16'h0006, 0,16'hF000,16'h0006,1), "pre_rst");
      do_reset("reset2");
      step(mk(0,0,16'h0000,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000,0), "midreq0");
      do_reset("reset3");
      step(mk(0,0,16'h0000,1,16'h0000, 1,16'h0000, 1,16'h0000,16'h0002,0), "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
